dut_arbiter: RTL and testbench

DUT_ARBITER -- requirements
Module: dut_arbiter

---
 rtl/dut_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dut_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_arbiter.sv
// dut_arbiter
//   Two-requester, round-robin arbiter in front of a downstream memory that
//   exposes separate write and read methods. One command is in flight at a
//   time: IDLE (grant) -> ISSUE (fire method or time out) -> RESP (one-cycle
//   completion pulse to the granted requester) -> IDLE.
//
// Parameters
//   TIMEOUT        ISSUE cycles with downstream rdy low tolerated before an
//                  error response (1..255).
//
// Ports
//   CLK, RST_N                       clock, asynchronous active-low reset
//   reqN_valid/wr/addr/wdata         requester N command (N = 0, 1)
//   reqN_ready                       one-cycle accept pulse to requester N
//   rspN_valid/data/err              one-cycle completion to requester N
//   write_address/data/en, write_rdy downstream write method
//   read_address/en, read_data/rdy   downstream read method
module dut_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,

  input  logic       req0_valid,
  input  logic       req0_wr,
  input  logic [2:0] req0_addr,
  input  logic       req0_wdata,
  output logic       req0_ready,

  input  logic       req1_valid,
  input  logic       req1_wr,
  input  logic [2:0] req1_addr,
  input  logic       req1_wdata,
  output logic       req1_ready,

  output logic       rsp0_valid,
  output logic       rsp0_data,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  output logic       rsp1_data,
  output logic       rsp1_err,

  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,

  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy
);

  localparam logic [7:0] TO = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  logic       rr_ptr;    // requester preferred on the next tie
  logic       gnt_q;     // requester owning the current transaction
  logic       wr_q;
  logic [2:0] addr_q;
  logic       wdata_q;
  logic [7:0] wait_cnt;
  logic       rdata_q;
  logic       err_q;

  logic       grant_valid;
  logic       grant_id;
  logic       in_issue;
  logic       fire;
  logic       timed_out;
  logic       in_resp;

  // Grant is decided combinationally in IDLE so the accept pulse lands in
  // the same cycle as the latch; gating with RST_N keeps ready low while
  // reset is asserted.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (RST_N && state == IDLE && (req0_valid || req1_valid)) begin
      grant_valid = 1'b1;
      if (req0_valid && req1_valid) grant_id = rr_ptr;
      else                          grant_id = req1_valid;
    end
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid &  grant_id;

  assign in_issue = (state == ISSUE);
  assign in_resp  = (state == RESP);

  // Methods fire straight from rdy while issuing.
  assign write_en  = in_issue &  wr_q & write_rdy;
  assign read_en   = in_issue & ~wr_q & read_rdy;
  assign fire      = write_en | read_en;
  // The cycle whose increment brings the counter to TIMEOUT is the last one
  // allowed; it ends the ISSUE phase with an error.
  assign timed_out = in_issue & ~fire & ((wait_cnt + 8'd1) == TO);

  assign write_address = (in_issue &  wr_q) ? addr_q : '0;
  assign write_data    =  in_issue &  wr_q  & wdata_q;
  assign read_address  = (in_issue & ~wr_q) ? addr_q : '0;

  assign rsp0_valid = in_resp & ~gnt_q;
  assign rsp1_valid = in_resp &  gnt_q;
  assign rsp0_data  = rsp0_valid & rdata_q;
  assign rsp1_data  = rsp1_valid & rdata_q;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 1'b0;
      wait_cnt <= '0;
      rdata_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            gnt_q    <= grant_id;
            rr_ptr   <= ~grant_id;
            wr_q     <= grant_id ? req1_wr    : req0_wr;
            addr_q   <= grant_id ? req1_addr  : req0_addr;
            wdata_q  <= grant_id ? req1_wdata : req0_wdata;
            wait_cnt <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            rdata_q <= read_en & read_data;
            err_q   <= 1'b0;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timed_out) begin
              rdata_q <= 1'b0;
              err_q   <= 1'b1;
              state   <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_arbiter.sv
// tb_dut_arbiter
//   Directed-vector bench for dut_arbiter. Inputs change 1 ns after the
//   rising edge; outputs are sampled on the falling edge.
module tb_dut_arbiter;

  logic       CLK;
  logic       RST_N;
  logic       req0_valid, req0_wr, req0_wdata, req0_ready;
  logic [2:0] req0_addr;
  logic       req1_valid, req1_wr, req1_wdata, req1_ready;
  logic [2:0] req1_addr;
  logic       rsp0_valid, rsp0_data, rsp0_err;
  logic       rsp1_valid, rsp1_data, rsp1_err;
  logic [2:0] write_address;
  logic       write_data, write_en, write_rdy;
  logic [2:0] read_address;
  logic       read_en, read_data, read_rdy;

  int unsigned vec_cnt;
  int unsigned err_cnt;

  dut_arbiter #(.TIMEOUT(15)) u_dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .req0_valid    (req0_valid),
    .req0_wr       (req0_wr),
    .req0_addr     (req0_addr),
    .req0_wdata    (req0_wdata),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_wr       (req1_wr),
    .req1_addr     (req1_addr),
    .req1_wdata    (req1_wdata),
    .req1_ready    (req1_ready),
    .rsp0_valid    (rsp0_valid),
    .rsp0_data     (rsp0_data),
    .rsp0_err      (rsp0_err),
    .rsp1_valid    (rsp1_valid),
    .rsp1_data     (rsp1_data),
    .rsp1_err      (rsp1_err),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic clr();
    req0_valid = 0; req0_wr = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_wr = 0; req1_addr = 0; req1_wdata = 0;
    write_rdy  = 0; read_rdy = 0; read_data = 0;
  endtask

  initial begin
    logic exp_g;
    vec_cnt = 0;
    err_cnt = 0;
    clr();

    // Reset with a request pending: nothing may be accepted or driven.
    RST_N = 0;
    req0_valid = 1; req0_wr = 1; req0_addr = 3'd5; req0_wdata = 1;
    write_rdy = 1; read_rdy = 1; read_data = 1;
    repeat (2) begin
      mid();
      chk("rst_ready0", req0_ready, 0);
      chk("rst_rsp0",   rsp0_valid, 0);
      chk("rst_wen",    write_en, 0);
      chk("rst_ren",    read_en, 0);
      chk("rst_waddr",  write_address, 0);
      cyc();
    end
    RST_N = 1;

    // req0 write addr 5 data 1, write_rdy high.
    mid();
    chk("w_ready0", req0_ready, 1);
    chk("w_ready1", req1_ready, 0);
    cyc();
    req0_valid = 0;
    mid();
    chk("w_en",    write_en, 1);
    chk("w_addr",  write_address, 5);
    chk("w_data",  write_data, 1);
    chk("w_ren",   read_en, 0);
    chk("w_early", rsp0_valid, 0);
    cyc();
    mid();
    chk("w_rsp0",  rsp0_valid, 1);
    chk("w_err0",  rsp0_err, 0);
    chk("w_dat0",  rsp0_data, 0);
    chk("w_en_off", write_en, 0);
    chk("w_addr0", write_address, 0);
    cyc();

    // req1 read addr 3, read_data 1.
    clr();
    req1_valid = 1; req1_wr = 0; req1_addr = 3'd3;
    read_rdy = 1; read_data = 1;
    mid();
    chk("r_ready1", req1_ready, 1);
    chk("r_ready0", req0_ready, 0);
    cyc();
    req1_valid = 0;
    mid();
    chk("r_en",   read_en, 1);
    chk("r_addr", read_address, 3);
    chk("r_wen",  write_en, 0);
    cyc();
    mid();
    chk("r_rsp1", rsp1_valid, 1);
    chk("r_dat1", rsp1_data, 1);
    chk("r_err1", rsp1_err, 0);
    chk("r_rsp0", rsp0_valid, 0);
    cyc();

    // Fresh reset, then both requesters valid continuously: 0,1,0,1.
    RST_N = 0;
    cyc();
    RST_N = 1;
    clr();
    req0_valid = 1; req0_wr = 1; req0_addr = 3'd2; req0_wdata = 1;
    req1_valid = 1; req1_wr = 0; req1_addr = 3'd6;
    write_rdy = 1; read_rdy = 1; read_data = 1;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      mid();
      chk("rr_ready0", req0_ready, {7'd0, ~exp_g});
      chk("rr_ready1", req1_ready, {7'd0, exp_g});
      cyc();
      mid();
      chk("rr_wen", write_en, {7'd0, ~exp_g});
      chk("rr_ren", read_en,  {7'd0, exp_g});
      cyc();
      mid();
      chk("rr_rsp0",  rsp0_valid, {7'd0, ~exp_g});
      chk("rr_rsp1",  rsp1_valid, {7'd0, exp_g});
      chk("rr_dat1",  rsp1_data,  {7'd0, exp_g});
      chk("rr_dat0",  rsp0_data,  0);
      cyc();
    end

    // Write with write_rdy low for 4 ISSUE cycles.
    clr();
    req0_valid = 1; req0_wr = 1; req0_addr = 3'd7; req0_wdata = 0;
    mid();
    chk("ws_ready0", req0_ready, 1);
    cyc();
    req0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("ws_wen_lo", write_en, 0);
      chk("ws_addr",   write_address, 7);
      cyc();
    end
    write_rdy = 1;
    mid();
    chk("ws_wen", write_en, 1);
    cyc();
    mid();
    chk("ws_rsp0",    rsp0_valid, 1);
    chk("ws_err0",    rsp0_err, 0);
    chk("ws_wen_off", write_en, 0);
    cyc();

    // Read timeout: read_rdy never rises.
    clr();
    req0_valid = 1; req0_wr = 0; req0_addr = 3'd4;
    read_data = 1;
    mid();
    chk("to_ready0", req0_ready, 1);
    cyc();
    req0_valid = 0;
    for (int i = 0; i < 15; i++) begin
      mid();
      chk("to_ren",   read_en, 0);
      chk("to_rsp0",  rsp0_valid, 0);
      chk("to_raddr", read_address, 4);
      cyc();
    end
    mid();
    chk("to_rsp",   rsp0_valid, 1);
    chk("to_err",   rsp0_err, 1);
    chk("to_data",  rsp0_data, 0);
    chk("to_raddr0", read_address, 0);
    cyc();
    req1_valid = 1; req1_wr = 1; req1_addr = 3'd1; req1_wdata = 1;
    write_rdy = 1;
    mid();
    chk("to_next_ready1", req1_ready, 1);
    cyc();
    req1_valid = 0;
    mid();
    chk("to_next_wen",  write_en, 1);
    chk("to_next_addr", write_address, 1);
    cyc();
    mid();
    chk("to_next_rsp1", rsp1_valid, 1);
    chk("to_next_err1", rsp1_err, 0);
    cyc();

    // Reset during ISSUE after a grant to requester 0.
    clr();
    req0_valid = 1; req0_wr = 1; req0_addr = 3'd6; req0_wdata = 1;
    mid();
    chk("ar_ready0", req0_ready, 1);
    cyc();
    req0_valid = 0;
    mid();
    chk("ar_addr", write_address, 6);
    chk("ar_wen",  write_en, 0);
    #2;
    RST_N = 0;
    write_rdy = 1;
    #1;
    chk("ar_addr_rst", write_address, 0);
    chk("ar_data_rst", write_data, 0);
    chk("ar_wen_rst",  write_en, 0);
    cyc();
    req0_valid = 1; req0_wr = 0; req0_addr = 3'd1;
    req1_valid = 1; req1_wr = 0; req1_addr = 3'd2;
    read_rdy = 1; read_data = 1; write_rdy = 0;
    mid();
    chk("ar_hold_ready0", req0_ready, 0);
    chk("ar_hold_ready1", req1_ready, 0);
    chk("ar_hold_rsp0",   rsp0_valid, 0);
    cyc();
    RST_N = 1;
    mid();
    chk("ar_tie_ready0", req0_ready, 1);
    chk("ar_tie_ready1", req1_ready, 0);
    chk("ar_no_rsp0",    rsp0_valid, 0);
    cyc();
    req0_valid = 0; req1_valid = 0;
    mid();
    chk("ar_ren",     read_en, 1);
    chk("ar_raddr",   read_address, 1);
    chk("ar_no_rsp",  rsp0_valid, 0);
    cyc();
    mid();
    chk("ar_rsp0",  rsp0_valid, 1);
    chk("ar_dat0",  rsp0_data, 1);
    chk("ar_rsp1",  rsp1_valid, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
